// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch slice:
//               FSM state encoding, default widths, instruction field slices.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Default widths used by the fetch unit and its memory interface
  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_INSTR_W = 12;

  // Instruction word field boundaries: opcode [11:8], operand/address [7:0]
  localparam int OPC_HI = 11;
  localparam int OPC_LO = 8;
  localparam int OPR_HI = 7;
  localparam int OPR_LO = 0;

  // Fetch sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DELIVER = 2'd2,
    ST_FAULT   = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Program-memory read handshake between the fetch unit
//               (master) and program memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W
);

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Program counter with reset value, load (jump) and
//               wrap-around increment; holds otherwise. Load beats increment.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic              clk,
  input  wire logic              reset_ir,
  input  wire logic              load,
  input  wire logic [ADDR_W-1:0] load_addr,
  input  wire logic              inc,
  output logic      [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  // Next PC: jump target, sequential successor (natural wrap), or hold
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register with asynchronous reset
  always_ff @(posedge clk or posedge reset_ir) begin
    if (reset_ir) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch sequencer. Requests the word at the PC from program
//               memory, captures it on acknowledge, pulses REIR for one cycle
//               and advances the PC. A request that is never acknowledged
//               within TIMEOUT cycles parks the unit in a sticky fault.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  wire logic                clk,
  input  wire logic                reset_ir,
  input  wire logic                fetch_en,
  input  wire logic                jump_valid,
  input  wire logic [ADDR_W-1:0]   jump_addr,
  instruction_fetch_unit_if.master mem,
  output logic      [INSTR_W-1:0]  instruction,
  output logic                     REIR,
  output logic      [ADDR_W-1:0]   pc,
  output logic                     fetch_busy,
  output logic                     fetch_fault
);

  // Timeout counter is 8 bits wide, enough for TIMEOUT up to 255
  localparam int             CNT_W        = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_e       state_d,     state_q;
  logic               mem_req_d,   mem_req_q;
  logic               reir_d,      reir_q;
  logic               fault_d,     fault_q;
  logic [INSTR_W-1:0] instr_d,     instr_q;
  logic [CNT_W-1:0]   cnt_d,       cnt_q;
  logic               pend_d,      pend_q;
  logic [ADDR_W-1:0]  pend_addr_d, pend_addr_q;

  logic               pc_load;
  logic [ADDR_W-1:0]  pc_load_addr;
  logic               pc_inc;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset_ir  (reset_ir),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .inc       (pc_inc),
    .pc        (pc)
  );

  // Next-state logic; mem_req and REIR are computed one cycle ahead so that
  // they come straight from flops
  always_comb begin
    state_d      = state_q;
    mem_req_d    = 1'b0;
    reir_d       = 1'b0;
    fault_d      = fault_q;
    instr_d      = instr_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pc_load      = 1'b0;
    pc_load_addr = jump_addr;
    pc_inc       = 1'b0;

    // A jump that arrives while busy (or faulted) is parked; latest wins
    if ((state_q != ST_IDLE) && jump_valid) begin
      pend_d      = 1'b1;
      pend_addr_d = jump_addr;
    end

    case (state_q)
      ST_IDLE: begin
        if (jump_valid) begin
          // Live jump beats both fetch_en and any older parked jump
          pc_load      = 1'b1;
          pc_load_addr = jump_addr;
          pend_d       = 1'b0;
        end else if (pend_q) begin
          // Parked jump replaces the incremented PC; IDLE is held this cycle
          pc_load      = 1'b1;
          pc_load_addr = pend_addr_q;
          pend_d       = 1'b0;
        end else if (fetch_en) begin
          state_d   = ST_REQ;
          mem_req_d = 1'b1;
          cnt_d     = '0;
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          // Ack has priority over a timeout in the same cycle
          instr_d = mem.mem_rdata;
          pc_inc  = 1'b1;
          reir_d  = 1'b1;
          state_d = ST_DELIVER;
        end else if (cnt_q == TIMEOUT_LAST) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          mem_req_d = 1'b1;
        end
      end
      ST_DELIVER: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers with asynchronous reset
  always_ff @(posedge clk or posedge reset_ir) begin
    if (reset_ir) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      reir_q      <= 1'b0;
      fault_q     <= 1'b0;
      instr_q     <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      reir_q      <= reir_d;
      fault_q     <= fault_d;
      instr_q     <= instr_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = pc;
  assign instruction  = instr_q;
  assign REIR         = reir_q;
  assign fetch_fault  = fault_q;
  assign fetch_busy   = (state_q == ST_REQ) || (state_q == ST_DELIVER);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit. Fetched words
//               are queued when the ack is driven and compared when REIR fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_ir = 1'b1;
  logic        fetch_en = 1'b0;
  logic        jump_valid = 1'b0;
  logic [7:0]  jump_addr = 8'h00;
  logic [11:0] instruction;
  logic        REIR;
  logic [7:0]  pc;
  logic        fetch_busy;
  logic        fetch_fault;

  instruction_fetch_unit_if #(.ADDR_W(8), .INSTR_W(12)) mem_if ();

  instruction_fetch_unit #(
    .ADDR_W   (8),
    .INSTR_W  (12),
    .RESET_PC (8'h00),
    .TIMEOUT  (15)
  ) dut (
    .clk         (clk),
    .reset_ir    (reset_ir),
    .fetch_en    (fetch_en),
    .jump_valid  (jump_valid),
    .jump_addr   (jump_addr),
    .mem         (mem_if),
    .instruction (instruction),
    .REIR        (REIR),
    .pc          (pc),
    .fetch_busy  (fetch_busy),
    .fetch_fault (fetch_fault)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int reir_pulses = 0;
  int reir_double = 0;
  logic reir_prev = 1'b0;
  logic [11:0] sb[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (REIR === 1'b1) reir_pulses++;
    if (REIR === 1'b1 && reir_prev === 1'b1) reir_double++;
    reir_prev = REIR;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_ir = 1'b1;
    fetch_en = 1'b0;
    jump_valid = 1'b0;
    mem_if.mem_ack = 1'b0;
    tick();
    tick();
    reset_ir = 1'b0;
  endtask

  // Assumes mem_req already high; acks after 'waits' stall cycles
  task automatic serve(input int waits, input logic [11:0] data,
                       output int req_cycles, output bit stable, output logic [7:0] addr0);
    req_cycles = 0;
    stable = 1'b1;
    addr0 = mem_if.mem_addr;
    for (int i = 0; i <= waits; i++) begin
      if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== addr0) stable = 1'b0;
      req_cycles++;
      if (i == waits) begin
        mem_if.mem_ack = 1'b1;
        mem_if.mem_rdata = data;
        sb.push_back(data);
      end
      tick();
    end
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = 12'hFFF;
  endtask

  task automatic start_fetch();
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++; if (pc !== 8'h00) $display("FAIL reset_pc: got %h want 00", pc); else pass_cnt++;
    total_cnt++; if (mem_if.mem_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", mem_if.mem_addr); else pass_cnt++;
    total_cnt++; if (instruction !== 12'h000) $display("FAIL reset_instr: got %h want 000", instruction); else pass_cnt++;
    total_cnt++; if (REIR !== 1'b0) $display("FAIL reset_reir: got %b want 0", REIR); else pass_cnt++;
    total_cnt++; if (mem_if.mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", mem_if.mem_req); else pass_cnt++;
    total_cnt++; if (fetch_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", fetch_busy); else pass_cnt++;
    total_cnt++; if (fetch_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fetch_fault); else pass_cnt++;
  endtask

  task automatic test_basic_fetch();
    int p0;
    logic [11:0] e;
    p0 = reir_pulses;
    start_fetch();
    total_cnt++; if (mem_if.mem_req !== 1'b1) $display("FAIL basic_req: got %b want 1", mem_if.mem_req); else pass_cnt++;
    total_cnt++; if (REIR !== 1'b0) $display("FAIL basic_reir_early: got %b want 0", REIR); else pass_cnt++;
    mem_if.mem_ack = 1'b1;
    mem_if.mem_rdata = 12'hA5C;
    sb.push_back(12'hA5C);
    tick();
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = 12'hFFF;
    total_cnt++; if (REIR !== 1'b1) $display("FAIL basic_reir: got %b want 1", REIR); else pass_cnt++;
    e = (sb.size() != 0) ? sb.pop_front() : 12'hxxx;
    total_cnt++; if (instruction !== e) $display("FAIL basic_instr: got %h want %h", instruction, e); else pass_cnt++;
    total_cnt++; if (pc !== 8'h01) $display("FAIL basic_pc: got %h want 01", pc); else pass_cnt++;
    total_cnt++; if (fetch_busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", fetch_busy); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (reir_pulses - p0 !== 1) $display("FAIL basic_pulses: got %0d want 1", reir_pulses - p0); else pass_cnt++;
    total_cnt++; if (fetch_busy !== 1'b0) $display("FAIL basic_idle: got %b want 0", fetch_busy); else pass_cnt++;
  endtask

  task automatic test_jump_wrap();
    int rc;
    bit st;
    logic [7:0] a0;
    logic [11:0] e;
    jump_valid = 1'b1;
    jump_addr = 8'hFF;
    fetch_en = 1'b1;
    tick();
    jump_valid = 1'b0;
    total_cnt++; if (pc !== 8'hFF) $display("FAIL jump_pc: got %h want FF", pc); else pass_cnt++;
    total_cnt++; if (mem_if.mem_req !== 1'b0) $display("FAIL jump_noreq: got %b want 0", mem_if.mem_req); else pass_cnt++;
    tick();
    fetch_en = 1'b0;
    total_cnt++; if (mem_if.mem_req !== 1'b1) $display("FAIL jump_req: got %b want 1", mem_if.mem_req); else pass_cnt++;
    serve(0, 12'h3C1, rc, st, a0);
    total_cnt++; if (a0 !== 8'hFF) $display("FAIL jump_addr: got %h want FF", a0); else pass_cnt++;
    total_cnt++; if (REIR !== 1'b1) $display("FAIL jump_reir: got %b want 1", REIR); else pass_cnt++;
    e = (sb.size() != 0) ? sb.pop_front() : 12'hxxx;
    total_cnt++; if (instruction !== e) $display("FAIL jump_instr: got %h want %h", instruction, e); else pass_cnt++;
    total_cnt++; if (pc !== 8'h00) $display("FAIL jump_wrap_pc: got %h want 00", pc); else pass_cnt++;
    tick();
  endtask

  task automatic test_wait_states();
    int rc;
    bit st;
    logic [7:0] a0;
    logic [11:0] e;
    start_fetch();
    serve(5, 12'h7E2, rc, st, a0);
    total_cnt++; if (rc !== 6) $display("FAIL wait_cycles: got %0d want 6", rc); else pass_cnt++;
    total_cnt++; if (st !== 1'b1) $display("FAIL wait_stable: got %b want 1", st); else pass_cnt++;
    total_cnt++; if (a0 !== 8'h00) $display("FAIL wait_addr: got %h want 00", a0); else pass_cnt++;
    total_cnt++; if (REIR !== 1'b1) $display("FAIL wait_reir: got %b want 1", REIR); else pass_cnt++;
    e = (sb.size() != 0) ? sb.pop_front() : 12'hxxx;
    total_cnt++; if (instruction !== e) $display("FAIL wait_instr: got %h want %h", instruction, e); else pass_cnt++;
    total_cnt++; if (fetch_fault !== 1'b0) $display("FAIL wait_fault: got %b want 0", fetch_fault); else pass_cnt++;
    tick();
    total_cnt++; if (REIR !== 1'b0) $display("FAIL wait_reir_once: got %b want 0", REIR); else pass_cnt++;
    // Ack on the very last allowed REQ cycle still completes the fetch
    start_fetch();
    serve(14, 12'h1D4, rc, st, a0);
    total_cnt++; if (REIR !== 1'b1 || fetch_fault !== 1'b0) $display("FAIL ack_wins: got reir=%b fault=%b want reir=1 fault=0", REIR, fetch_fault); else pass_cnt++;
    e = (sb.size() != 0) ? sb.pop_front() : 12'hxxx;
    total_cnt++; if (instruction !== e) $display("FAIL ack_wins_instr: got %h want %h", instruction, e); else pass_cnt++;
    total_cnt++; if (pc !== 8'h02) $display("FAIL ack_wins_pc: got %h want 02", pc); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    int rc;
    bit st;
    logic [7:0] a0;
    logic [11:0] e;
    int t[3];
    int k;
    fetch_en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      k = 0;
      while (mem_if.mem_req !== 1'b1 && k < 6) begin
        tick();
        k++;
      end
      if (n == 2) fetch_en = 1'b0;
      serve(0, 12'h800 + 12'(n), rc, st, a0);
      t[n] = cyc;
      total_cnt++; if (a0 !== 8'h02 + 8'(n)) $display("FAIL b2b_addr%0d: got %h want %h", n, a0, 8'h02 + 8'(n)); else pass_cnt++;
      e = (sb.size() != 0) ? sb.pop_front() : 12'hxxx;
      total_cnt++; if (REIR !== 1'b1 || instruction !== e) $display("FAIL b2b_instr%0d: got %h reir=%b want %h reir=1", n, instruction, REIR, e); else pass_cnt++;
    end
    fetch_en = 1'b0;
    total_cnt++; if (t[1] - t[0] !== 3) $display("FAIL b2b_period0: got %0d want 3", t[1] - t[0]); else pass_cnt++;
    total_cnt++; if (t[2] - t[1] !== 3) $display("FAIL b2b_period1: got %0d want 3", t[2] - t[1]); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (pc !== 8'h05) $display("FAIL b2b_pc: got %h want 05", pc); else pass_cnt++;
  endtask

  task automatic test_pending_jump();
    logic [11:0] e;
    jump_valid = 1'b1;
    jump_addr = 8'h10;
    tick();
    jump_valid = 1'b0;
    start_fetch();
    total_cnt++; if (mem_if.mem_addr !== 8'h10) $display("FAIL pend_addr: got %h want 10", mem_if.mem_addr); else pass_cnt++;
    jump_valid = 1'b1;
    jump_addr = 8'h40;
    tick();
    jump_valid = 1'b0;
    total_cnt++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 8'h10) $display("FAIL pend_hold: got req=%b addr=%h want req=1 addr=10", mem_if.mem_req, mem_if.mem_addr); else pass_cnt++;
    mem_if.mem_ack = 1'b1;
    mem_if.mem_rdata = 12'h2B7;
    sb.push_back(12'h2B7);
    tick();
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = 12'hFFF;
    e = (sb.size() != 0) ? sb.pop_front() : 12'hxxx;
    total_cnt++; if (REIR !== 1'b1 || instruction !== e) $display("FAIL pend_fetch: got %h reir=%b want %h reir=1", instruction, REIR, e); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (pc !== 8'h40) $display("FAIL pend_pc: got %h want 40", pc); else pass_cnt++;
    total_cnt++; if (mem_if.mem_req !== 1'b0) $display("FAIL pend_idle: got %b want 0", mem_if.mem_req); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    int p0;
    p0 = reir_pulses;
    start_fetch();
    n = 0;
    while (mem_if.mem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    total_cnt++; if (n !== 15) $display("FAIL to_cycles: got %0d want 15", n); else pass_cnt++;
    total_cnt++; if (fetch_fault !== 1'b1) $display("FAIL to_fault: got %b want 1", fetch_fault); else pass_cnt++;
    total_cnt++; if (fetch_busy !== 1'b0) $display("FAIL to_busy: got %b want 0", fetch_busy); else pass_cnt++;
    fetch_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_if.mem_ack = i[0];
      mem_if.mem_rdata = 12'h555;
      tick();
    end
    mem_if.mem_ack = 1'b0;
    fetch_en = 1'b0;
    total_cnt++; if (fetch_fault !== 1'b1 || mem_if.mem_req !== 1'b0) $display("FAIL to_sticky: got fault=%b req=%b want fault=1 req=0", fetch_fault, mem_if.mem_req); else pass_cnt++;
    total_cnt++; if (reir_pulses - p0 !== 0) $display("FAIL to_noreir: got %0d want 0", reir_pulses - p0); else pass_cnt++;
    apply_reset();
    total_cnt++; if (fetch_fault !== 1'b0) $display("FAIL to_clear: got %b want 0", fetch_fault); else pass_cnt++;
  endtask

  task automatic test_reset_mid_req();
    jump_valid = 1'b1;
    jump_addr = 8'h55;
    tick();
    jump_valid = 1'b0;
    start_fetch();
    total_cnt++; if (mem_if.mem_req !== 1'b1) $display("FAIL rst_req_pre: got %b want 1", mem_if.mem_req); else pass_cnt++;
    #2;
    reset_ir = 1'b1;
    #1;
    total_cnt++; if (mem_if.mem_req !== 1'b0) $display("FAIL rst_async_req: got %b want 0", mem_if.mem_req); else pass_cnt++;
    total_cnt++; if (pc !== 8'h00) $display("FAIL rst_async_pc: got %h want 00", pc); else pass_cnt++;
    mem_if.mem_ack = 1'b1;
    mem_if.mem_rdata = 12'hBEE;
    tick();
    reset_ir = 1'b0;
    tick();
    mem_if.mem_ack = 1'b0;
    total_cnt++; if (REIR !== 1'b0 || instruction !== 12'h000) $display("FAIL rst_ack_ignored: got reir=%b instr=%h want reir=0 instr=000", REIR, instruction); else pass_cnt++;
    total_cnt++; if (pc !== 8'h00 || mem_if.mem_req !== 1'b0 || fetch_busy !== 1'b0) $display("FAIL rst_state: got pc=%h req=%b busy=%b want pc=00 req=0 busy=0", pc, mem_if.mem_req, fetch_busy); else pass_cnt++;
  endtask

  initial begin
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = 12'hFFF;
    test_reset();
    test_basic_fetch();
    test_jump_wrap();
    test_wait_states();
    test_back_to_back();
    test_pending_jump();
    test_timeout();
    test_reset_mid_req();
    total_cnt++; if (reir_double !== 0) $display("FAIL reir_consecutive: got %0d want 0", reir_double); else pass_cnt++;
    total_cnt++; if (sb.size() !== 0) $display("FAIL sb_leftover: got %0d want 0", sb.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
